// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row sync, press/release debounce.
// Define KEYPAD_HEX_MAP_EN to emit printed-layout hex codes instead of raw codes.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int CMAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state;
  logic [3:0]    row_m;
  logic [3:0]    row_s;
  logic [3:0]    cap;
  logic [CW-1:0] cnt;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [3:0]    code;
  logic [3:0]    col_nxt;

  assign col_nxt = {col[2:0], col[3]};

  always_comb begin
    col_idx = 2'd0;
    unique case (1'b1)
      col[0]:  col_idx = 2'd0;
      col[1]:  col_idx = 2'd1;
      col[2]:  col_idx = 2'd2;
      col[3]:  col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Several rows at once resolve to the lowest one.
  always_comb begin
    row_idx = 2'd0;
    priority case (1'b1)
      cap[0]:  row_idx = 2'd0;
      cap[1]:  row_idx = 2'd1;
      cap[2]:  row_idx = 2'd2;
      cap[3]:  row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

`ifdef KEYPAD_HEX_MAP_EN
  always_comb begin
    code = 4'h0;
    case ({row_idx, col_idx})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
  end
`else
  assign code = {row_idx, col_idx};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_m     <= '0;
      row_s     <= '0;
      state     <= SCAN;
      cnt       <= '0;
      cap       <= '0;
      col       <= 4'b0001;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      row_m     <= row;
      row_s     <= row_m;
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (row_s != 4'd0) begin
              cap   <= row_s;
              state <= DEBOUNCE;
            end else begin
              col <= col_nxt;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DEBOUNCE: begin
          if (row_s != cap) begin
            cnt   <= '0;
            col   <= col_nxt;
            state <= SCAN;
          end else if (cnt == DEB_LAST) begin
            cnt       <= '0;
            state     <= HELD;
            key_code  <= code;
            key_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (row_s == 4'd0) begin
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (row_s != 4'd0) begin
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            col   <= col_nxt;
            state <= SCAN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random rows,
// every cycle compared against a behavioural model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row = 4'd0;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk(clk), .rst(rst), .row(row),
    .col(col), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] code_of(logic [3:0] r, int c);
    int hexmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    int ri = 0;
    for (int i = 3; i >= 0; i--) if (r[i]) ri = i;
`ifdef KEYPAD_HEX_MAP_EN
    return 4'(hexmap[ri * 4 + c]);
`else
    return 4'(ri * 4 + c);
`endif
  endfunction

  // Model: mode 0 scanning, 1 confirming press, 2 held, 3 confirming release.
  logic [3:0] q1, rs, capt, m_code;
  logic       m_valid;
  int         mode, colpos, t;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1 = 0; rs = 0; capt = 0; mode = 0; colpos = 0; t = 0;
      m_valid = 0; m_code = 0;
    end else begin
      m_valid = 0;
      case (mode)
        0: if (t == SD - 1) begin
             t = 0;
             if (rs != 0) begin capt = rs; mode = 1; end
             else colpos = (colpos + 1) % 4;
           end else t++;
        1: if (rs != capt) begin
             t = 0; colpos = (colpos + 1) % 4; mode = 0;
           end else if (t + 1 == DC) begin
             t = 0; mode = 2; m_valid = 1; m_code = code_of(capt, colpos);
           end else t++;
        2: if (rs == 0) begin mode = 3; t = 0; end
        default:
           if (rs != 0) begin mode = 2; t = 0; end
           else if (t + 1 == DC) begin
             t = 0; mode = 0; colpos = (colpos + 1) % 4;
           end else t++;
      endcase
      rs = q1;
      q1 = row;
    end
  end

  int         dut_events = 0;
  logic [3:0] last_code = 0;
  logic       prev_kv = 0;

  always @(negedge clk) begin
    checks++;
    if (col !== 4'(1 << colpos)) begin
      errors++; $display("FAIL col: got %b want %b", col, 4'(1 << colpos));
    end
    checks++;
    if (key_valid !== m_valid) begin
      errors++; $display("FAIL key_valid: got %b want %b", key_valid, m_valid);
    end
    checks++;
    if (key_code !== m_code) begin
      errors++; $display("FAIL key_code: got %h want %h", key_code, m_code);
    end
    checks++;
    if (key_valid && prev_kv) begin
      errors++; $display("FAIL pulse_width: got 2 cycles want 1");
    end
    prev_kv = key_valid;
    if (key_valid) begin dut_events++; last_code = key_code; end
  end

  task automatic expect4(string nm, logic [3:0] got, logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic expect_int(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++; $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_col(logic [3:0] target, int budget);
    int n = 0;
    while (col == target && n < budget) begin @(posedge clk); #1; n++; end
    while (col != target && n < budget) begin @(posedge clk); #1; n++; end
    expect4("wait_col", col, target);
  endtask

`ifdef KEYPAD_HEX_MAP_EN
  localparam logic [3:0] C_CLEAN = 4'h6, C_BOUNCE = 4'h7, C_MULTI = 4'hB;
`else
  localparam logic [3:0] C_CLEAN = 4'h6, C_BOUNCE = 4'h8, C_MULTI = 4'h7;
`endif

  initial begin
    #400000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int ev0;
    int hold;
    logic [3:0] v;
    #1 rst = 1'b0;
    row = 4'($urandom);
    step(3);
    expect4("rst col", col, 4'b0001);
    expect4("rst key_code", key_code, 4'h0);
    expect4("rst key_valid", {3'b0, key_valid}, 4'h0);
    row = 4'd0;
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(SD);
      expect4("scan col", col, 4'(1 << (i % 4)));
    end

    wait_col(4'b0100, 40);
    row = 4'b0010;
    ev0 = dut_events;
    step(40);
    expect4("clean col", col, 4'b0100);
    expect_int("clean events", dut_events - ev0, 1);
    expect4("clean code", last_code, C_CLEAN);
    row = 4'd0;
    step(14);

    wait_col(4'b0001, 40);
    ev0 = dut_events;
    for (int i = 0; i < 10; i++) begin
      row = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      step(3);
    end
    expect_int("bounce events", dut_events - ev0, 0);
    row = 4'd0;
    wait_col(4'b0001, 40);
    row = 4'b0100;
    ev0 = dut_events;
    step(16);
    expect_int("stable events", dut_events - ev0, 1);
    expect4("stable code", last_code, C_BOUNCE);

    ev0 = dut_events;
    row = 4'd0;
    step(5);
    row = 4'b0100;
    step(10);
    expect_int("glitch events", dut_events - ev0, 0);
    expect4("glitch col", col, 4'b0001);
    row = 4'd0;
    wait_col(4'b0010, 30);
    expect_int("release events", dut_events - ev0, 0);

    wait_col(4'b1000, 40);
    row = 4'b1010;
    ev0 = dut_events;
    step(16);
    expect_int("multi events", dut_events - ev0, 1);
    expect4("multi code", last_code, C_MULTI);
    row = 4'd0;
    step(14);

    wait_col(4'b0001, 40);
    row = 4'b0001;
    step(5);
    ev0 = dut_events;
    rst = 1'b0;
    #1;
    expect4("midrst col", col, 4'b0001);
    expect4("midrst key_code", key_code, 4'h0);
    expect4("midrst key_valid", {3'b0, key_valid}, 4'h0);
    step(3);
    expect_int("midrst events", dut_events - ev0, 0);
    rst = 1'b1;
    step(20);
    row = 4'd0;
    step(14);

    for (int b = 0; b < 60; b++) begin
      case ($urandom_range(0, 3))
        0:       v = 4'd0;
        3:       v = 4'($urandom);
        default: v = 4'(1 << $urandom_range(0, 3));
      endcase
      row = v;
      hold = $urandom_range(1, 25);
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b0;
        step(2);
        rst = 1'b1;
      end
      step(hold);
    end
    row = 4'd0;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
